// File: rtl/ws2812_frame_reader_if.sv
// Pixel RAM read port and strip-side status signals of the WS2812B frame reader.
// The master modport belongs to the reader; the slave modport belongs to the RAM/game side.
interface ws2812_frame_reader_if #(
  parameter int AW   = 4,
  parameter int SIZE = 24
);
  logic            update;
  logic [AW-1:0]   raddr;
  logic [SIZE-1:0] read_data;
  logic            data_out;
  logic            busy;
  logic            frame_done;

  modport master (
    input  update, read_data,
    output raddr, data_out, busy, frame_done
  );

  modport slave (
    output update, read_data,
    input  raddr, data_out, busy, frame_done
  );
endinterface

// File: rtl/ws2812_frame_reader.sv
// WS2812B frame reader: walks the pixel RAM, shifts each GRB word onto
// the strip line MSB first, then holds the line low for the latch gap.
module ws2812_frame_reader #(
  parameter int PIXEL_COUNT  = 16,
  parameter int SIZE         = 24,
  parameter int BIT_CYCLES   = 125,
  parameter int T0H_CYCLES   = 40,
  parameter int T1H_CYCLES   = 80,
  parameter int RESET_CYCLES = 30000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ws2812_frame_reader_if.master bus
);
  localparam int AW   = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1;
  localparam int BW   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CMAX = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES
                                                    : RESET_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RESET_CYCLES - 1);
  localparam logic [BW-1:0] SIZE_LAST = BW'(SIZE - 1);
  localparam logic [AW-1:0] PIX_LAST  = AW'(PIXEL_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, SEND, LATCH
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [AW-1:0]   pix_q, pix_d;
  logic [SIZE-1:0] shreg_q, shreg_d;
  logic            pending_q, pending_d;
  logic            data_out_q, data_out_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [31:0]     th_d;

  assign bus.raddr      = pix_q;
  assign bus.data_out   = data_out_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    pix_d     = pix_q;
    shreg_d   = shreg_q;
    pending_d = pending_q;
    if (state_q != IDLE && bus.update) pending_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (bus.update) begin
          state_d = FETCH;
          pix_d   = '0;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        shreg_d = bus.read_data;
        bit_d   = '0;
        cnt_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = shreg_q << 1;
          bit_d   = bit_q + BW'(1);
          if (bit_q == SIZE_LAST) begin
            bit_d = '0;
            if (pix_q == PIX_LAST) begin
              state_d = LATCH;
            end else begin
              pix_d   = pix_q + AW'(1);
              state_d = FETCH;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LATCH: begin
        if (cnt_q == RST_LAST) begin
          // a request landing in this very cycle still chains the next frame
          cnt_d     = '0;
          pix_d     = '0;
          pending_d = 1'b0;
          state_d   = (pending_q || bus.update) ? FETCH : IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    th_d = shreg_d[SIZE-1] ? 32'(T1H_CYCLES) : 32'(T0H_CYCLES);
    data_out_d = (state_d == SEND) && (32'(cnt_d) < th_d);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == LATCH) && (cnt_d == RST_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      pix_q      <= '0;
      shreg_q    <= '0;
      pending_q  <= 1'b0;
      data_out_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      pix_q      <= pix_d;
      shreg_q    <= shreg_d;
      pending_q  <= pending_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end
endmodule

// File: tb/tb_ws2812_frame_reader.sv
// Directed bench for ws2812_frame_reader with a 2-pixel behavioural RAM
// and shortened strip timing.
module tb_ws2812_frame_reader;
  localparam int PC   = 2;
  localparam int SZ   = 24;
  localparam int BC   = 10;
  localparam int T0   = 3;
  localparam int T1   = 7;
  localparam int RC   = 20;
  localparam int FLEN = PC * (2 + SZ * BC) + RC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [SZ-1:0] mem [PC];

  ws2812_frame_reader_if #(.AW(1), .SIZE(SZ)) bus ();

  ws2812_frame_reader #(
    .PIXEL_COUNT (PC),
    .SIZE        (SZ),
    .BIT_CYCLES  (BC),
    .T0H_CYCLES  (T0),
    .T1H_CYCLES  (T1),
    .RESET_CYCLES(RC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.read_data <= mem[bus.raddr];

  int vec_n = 0;
  int bad = 0;

  typedef struct {
    logic [23:0] m0;
    logic [23:0] m1;
    int          wr_at;
    logic [23:0] wr_val;
    int          exp_high;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_update();
    @(negedge clk);
    bus.update = 1'b1;
    @(negedge clk);
    bus.update = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    logic q[$];
    logic e[$];
    logic [23:0] w;
    int n, high, mism, ra0, ra1;
    mem[0] = v.m0;
    mem[1] = v.m1;
    pulse_update();
    chk({nm, ".busy_rise"}, {31'd0, bus.busy}, 1);
    n = 0; high = 0; ra0 = -1; ra1 = -1;
    while (n < 2000) begin
      if (n == v.wr_at) mem[1] = v.wr_val;
      q.push_back(bus.data_out);
      if (n == 0) ra0 = int'(bus.raddr);
      if (n == 242) ra1 = int'(bus.raddr);
      high += int'(bus.data_out);
      n++;
      if (bus.frame_done) break;
      @(negedge clk);
    end
    for (int p = 0; p < PC; p++) begin
      w = (p == 0) ? v.m0 : ((v.wr_at >= 0) ? v.wr_val : v.m1);
      e.push_back(1'b0);
      e.push_back(1'b0);
      for (int b = SZ - 1; b >= 0; b--)
        for (int c = 0; c < BC; c++)
          e.push_back(c < (w[b] ? T1 : T0));
    end
    for (int c = 0; c < RC; c++) e.push_back(1'b0);
    mism = 0;
    for (int i = 0; i < e.size(); i++)
      if (i >= q.size() || q[i] !== e[i]) mism++;
    chk({nm, ".wave"}, mism, 0);
    chk({nm, ".len"}, n, FLEN);
    chk({nm, ".high"}, high, v.exp_high);
    chk({nm, ".raddr0"}, ra0, 0);
    chk({nm, ".raddr1"}, ra1, 1);
    @(negedge clk);
    chk({nm, ".busy_fall"}, {31'd0, bus.busy}, 0);
    chk({nm, ".done_once"}, {31'd0, bus.frame_done}, 0);
  endtask

  task automatic watch(input int u1, input int u2, input int u3,
                       input string nm);
    int n, nfd, fd1, fd2;
    mem[0] = 24'h800001;
    mem[1] = 24'h000000;
    pulse_update();
    n = 0; nfd = 0; fd1 = -1; fd2 = -1;
    while (n < 3000 && bus.busy) begin
      if (bus.frame_done) begin
        nfd++;
        if (nfd == 1) fd1 = n;
        else fd2 = n;
      end
      bus.update = (n == u1 || n == u2 || n == u3);
      n++;
      @(negedge clk);
    end
    bus.update = 1'b0;
    chk({nm, ".len"}, n, 2 * FLEN);
    chk({nm, ".ndone"}, nfd, 2);
    chk({nm, ".done1"}, fd1, FLEN - 1);
    chk({nm, ".done2"}, fd2, 2 * FLEN - 1);
    repeat (3) @(negedge clk);
    chk({nm, ".idle"}, {31'd0, bus.busy}, 0);
  endtask

  initial begin
    tbl[0] = '{24'h800001, 24'h000000, -1, 24'h0, 152};
    tbl[1] = '{24'hFFFFFF, 24'h000000, -1, 24'h0, 240};
    tbl[2] = '{24'hAAAAAA, 24'h555555, -1, 24'h0, 240};
    tbl[3] = '{24'h000000, 24'h000000, -1, 24'h0, 144};
    tbl[4] = '{24'hFFFFFF, 24'hFFFFFF, -1, 24'h0, 336};
    tbl[5] = '{24'h0F0F0F, 24'h000001, -1, 24'h0, 196};
    tbl[6] = '{24'h800001, 24'h000000, 50, 24'hFFFFFF, 248};
    mem[0] = '0;
    mem[1] = '0;
    bus.update = 1'b0;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.update = i[0];
      chk("rst.outs", {28'd0, bus.data_out, bus.busy,
                       bus.frame_done, bus.raddr}, 0);
    end
    @(negedge clk);
    bus.update = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.idle", {31'd0, bus.busy}, 0);

    for (int i = 0; i < 7; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
      repeat (2) @(negedge clk);
    end

    watch(30, 60, 90, "coalesce");
    watch(FLEN - 1, -1, -1, "b2b");

    mem[0] = 24'hFFFFFF;
    mem[1] = 24'h000000;
    pulse_update();
    repeat (4) @(negedge clk);
    chk("arst.high", {31'd0, bus.data_out}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.drop", {31'd0, bus.data_out}, 0);
    chk("arst.busy", {31'd0, bus.busy}, 0);
    chk("arst.raddr", {31'd0, bus.raddr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("arst.idle", {30'd0, bus.busy, bus.data_out}, 0);
    run_vec(tbl[0], "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, bad);
    $finish;
  end
endmodule
